ldpc_loop_sequencer: RTL
========================

# ldpc_loop_sequencer

Job sequencer for the LDPC encoder→decoder loopback. It accepts one job descriptor at a time and issues that descriptor as the control word to both the encoder and the decoder control streams. It then collects one status word from each and emits a single result word carrying a mismatch flag, a timeout flag and the measured loop latency. It sits in front of the loop wrapper's two control inputs and two status outputs and keeps job/error statistics.

## Interface
- DATA_WIDTH, 32: width of job, control, status and result words; elaboration error if DATA_WIDTH < CNT_WIDTH+2
- CNT_WIDTH, 16: width of latency field and statistic counters
- TIMEOUT_CYCLES, 4096: status wait limit in cycles (1 ≤ TIMEOUT_CYCLES ≤ 2^CNT_WIDTH−1)

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- s_axis_job_tdata / _tvalid / _tready  in/in/out  DATA_WIDTH/1/1  job descriptor
- m_axis_enc_ctrl_tdata / _tvalid / _tready  out/out/in  DATA_WIDTH/1/1  encoder control word
- m_axis_dec_ctrl_tdata / _tvalid / _tready  out/out/in  DATA_WIDTH/1/1  decoder control word
- s_axis_enc_status_tdata / _tvalid / _tready  in/in/out  DATA_WIDTH/1/1  encoder status
- s_axis_dec_status_tdata / _tvalid / _tready  in/in/out  DATA_WIDTH/1/1  decoder status
- m_axis_result_tdata / _tvalid / _tready  out/out/in  DATA_WIDTH/1/1  job result
- busy  out  1  high in any state except IDLE
- job_count  out  CNT_WIDTH  completed jobs, saturating
- error_count  out  CNT_WIDTH  jobs with timeout or mismatch, saturating

## Operation
- States: IDLE, ISSUE, WAIT, REPORT.
- IDLE:
  - s_axis_job_tready=1.
  - Both status treadys are 1; any status words arriving here are stale and are discarded.
  - On job handshake: latch tdata, clear enc/dec done flags, clear elapsed counter, go to ISSUE.
- ISSUE:
  - enc_ctrl and dec_ctrl tvalid both asserted with the latched job word.
  - Each tvalid drops independently after its own handshake.
  - No timeout applies in ISSUE; tvalid is never retracted before its handshake.
  - Go to WAIT once both control handshakes have completed.
- Status capture (ISSUE and WAIT):
  - Each status tready is 1 while that status has not yet been captured.
  - On handshake, latch the word and set its done flag.
  - A status may be captured in the same cycle as the control handshake.
- WAIT:
  - Go to REPORT when both done flags are set.
  - Also go to REPORT when elapsed reaches TIMEOUT_CYCLES with a status still outstanding.
  - If the final status handshake and the timeout fall in the same cycle, the status wins: no timeout.
- REPORT:
  - m_axis_result_tvalid=1; tdata is held stable until tready.
  - On the result handshake, go to IDLE.
  - On the same handshake, job_count += 1 and, if bit T or bit M is set, error_count += 1 (both saturate at all-ones).
- Result word fields:
  - [DATA_WIDTH−1] = T (timeout).
  - [DATA_WIDTH−2] = M (mismatch): 1 when both statuses were received and enc_status ≠ dec_status. M is 0 on timeout.
  - [CNT_WIDTH−1:0] = elapsed.
  - All other bits are 0.
- elapsed:
  - Counts clock edges since the job handshake and saturates at 2^CNT_WIDTH−1.
  - It is frozen on the last status handshake, or at the timeout.

## Timing
- Job handshake at cycle 0 → control tvalid is high from cycle 1, with registered outputs.
- Result tvalid is asserted in the cycle after the last status handshake.
  - Minimum case: control and status handshakes at cycle 1 → result valid at cycle 2 with elapsed=1.
- On timeout, result tvalid is asserted the cycle after elapsed reaches TIMEOUT_CYCLES; elapsed field = TIMEOUT_CYCLES.
- One job in flight at a time. A new job can be accepted in the cycle after the result handshake, so the minimum job period is 3 cycles.
- Reset values: state=IDLE; all tvalid=0, all tdata=0, busy=0, job_count=0, error_count=0.
- While areset is high, all tready outputs are 0. From the first edge after release, the IDLE treadys are 1.
- Reset mid-job aborts the job with no result and no counter update.

## Test plan
- Job 0x0000_00A5, ctrl/status tready/tvalid always high, both statuses 0x1234 → result 0x0000_0001 (T=0, M=0, elapsed=1); job_count=1, error_count=0.
- Enc status 0x1, dec status 0x2, dec status delayed 10 cycles → M=1, elapsed=11, error_count=1.
- TIMEOUT_CYCLES=16, dec status never sent → result 0x8000_0010 at cycle 17. A dec status later arriving in IDLE is dropped; the next job completes normally.
- enc_ctrl_tready held low 20 cycles, dec_ctrl accepted immediately → enc tvalid held, no timeout during ISSUE, dec tvalid low after its handshake.
- Result tready low 5 cycles → tdata stable, job tready 0, counters unchanged until the handshake.
- areset pulsed mid-WAIT → all outputs to reset values, no result emitted, next job runs from elapsed=0.

Source files
------------

// File: rtl/ldpc_loop_sequencer.sv
// ldpc_loop_sequencer
// Runs one LDPC loopback job at a time. The job word goes out on both the
// encoder and decoder control streams. The sequencer then waits for one status
// word from each side and returns a result word that carries a timeout flag, a
// mismatch flag and the measured loop latency. Completed and failed jobs are
// counted in saturating counters.
module ldpc_loop_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic [DATA_WIDTH-1:0] s_axis_job_tdata,
    input  logic                  s_axis_job_tvalid,
    output logic                  s_axis_job_tready,

    output logic [DATA_WIDTH-1:0] m_axis_enc_ctrl_tdata,
    output logic                  m_axis_enc_ctrl_tvalid,
    input  logic                  m_axis_enc_ctrl_tready,

    output logic [DATA_WIDTH-1:0] m_axis_dec_ctrl_tdata,
    output logic                  m_axis_dec_ctrl_tvalid,
    input  logic                  m_axis_dec_ctrl_tready,

    input  logic [DATA_WIDTH-1:0] s_axis_enc_status_tdata,
    input  logic                  s_axis_enc_status_tvalid,
    output logic                  s_axis_enc_status_tready,

    input  logic [DATA_WIDTH-1:0] s_axis_dec_status_tdata,
    input  logic                  s_axis_dec_status_tvalid,
    output logic                  s_axis_dec_status_tready,

    output logic [DATA_WIDTH-1:0] m_axis_result_tdata,
    output logic                  m_axis_result_tvalid,
    input  logic                  m_axis_result_tready,

    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  job_count,
    output logic [CNT_WIDTH-1:0]  error_count
);

    // The T and M flags sit in the two top bits above the latency field.
    if (DATA_WIDTH < CNT_WIDTH + 2) begin : g_width_check
        $error("ldpc_loop_sequencer: DATA_WIDTH must be at least CNT_WIDTH+2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** CNT_WIDTH) - 1) begin : g_timeout_check
        $error("ldpc_loop_sequencer: TIMEOUT_CYCLES out of range for CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t                 state_q,       state_d;
    logic                   rdy_en_q;
    logic [DATA_WIDTH-1:0]  job_q,         job_d;
    logic                   enc_vld_q,     enc_vld_d;
    logic                   dec_vld_q,     dec_vld_d;
    logic                   enc_done_q,    enc_done_d;
    logic                   dec_done_q,    dec_done_d;
    logic [DATA_WIDTH-1:0]  enc_stat_q,    enc_stat_d;
    logic [DATA_WIDTH-1:0]  dec_stat_q,    dec_stat_d;
    logic [CNT_WIDTH-1:0]   elapsed_q,     elapsed_d;
    logic                   res_vld_q,     res_vld_d;
    logic [DATA_WIDTH-1:0]  res_data_q,    res_data_d;
    logic [CNT_WIDTH-1:0]   job_count_q,   job_count_d;
    logic [CNT_WIDTH-1:0]   error_count_q, error_count_d;

    logic                   in_flight;
    logic                   enc_status_rdy;
    logic                   dec_status_rdy;
    logic                   report_go;
    logic                   report_to;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] make_result(input logic                 t,
                                                          input logic                 m,
                                                          input logic [CNT_WIDTH-1:0] el);
        logic [DATA_WIDTH-1:0] r;
        r                  = '0;
        r[DATA_WIDTH-1]    = t;
        r[DATA_WIDTH-2]    = m;
        r[CNT_WIDTH-1:0]   = el;
        return r;
    endfunction

    // Ready outputs are held low until the first clock edge after reset release.
    assign in_flight      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign enc_status_rdy = rdy_en_q && ((state_q == ST_IDLE) || (in_flight && !enc_done_q));
    assign dec_status_rdy = rdy_en_q && ((state_q == ST_IDLE) || (in_flight && !dec_done_q));

    assign s_axis_job_tready        = rdy_en_q && (state_q == ST_IDLE);
    assign s_axis_enc_status_tready = enc_status_rdy;
    assign s_axis_dec_status_tready = dec_status_rdy;
    assign m_axis_enc_ctrl_tdata    = job_q;
    assign m_axis_enc_ctrl_tvalid   = enc_vld_q;
    assign m_axis_dec_ctrl_tdata    = job_q;
    assign m_axis_dec_ctrl_tvalid   = dec_vld_q;
    assign m_axis_result_tdata      = res_data_q;
    assign m_axis_result_tvalid     = res_vld_q;
    assign busy                     = (state_q != ST_IDLE);
    assign job_count                = job_count_q;
    assign error_count              = error_count_q;

    // Next-state logic: job accept, control issue, status capture, timeout and report.
    always_comb begin
        state_d       = state_q;
        job_d         = job_q;
        enc_vld_d     = enc_vld_q;
        dec_vld_d     = dec_vld_q;
        enc_done_d    = enc_done_q;
        dec_done_d    = dec_done_q;
        enc_stat_d    = enc_stat_q;
        dec_stat_d    = dec_stat_q;
        elapsed_d     = elapsed_q;
        res_vld_d     = res_vld_q;
        res_data_d    = res_data_q;
        job_count_d   = job_count_q;
        error_count_d = error_count_q;
        report_go     = 1'b0;
        report_to     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Status words seen here are stale and simply dropped.
                if (s_axis_job_tvalid && s_axis_job_tready) begin
                    job_d      = s_axis_job_tdata;
                    enc_vld_d  = 1'b1;
                    dec_vld_d  = 1'b1;
                    enc_done_d = 1'b0;
                    dec_done_d = 1'b0;
                    elapsed_d  = '0;
                    state_d    = ST_ISSUE;
                end
            end

            ST_ISSUE, ST_WAIT: begin
                if (s_axis_enc_status_tvalid && enc_status_rdy) begin
                    enc_stat_d = s_axis_enc_status_tdata;
                    enc_done_d = 1'b1;
                end
                if (s_axis_dec_status_tvalid && dec_status_rdy) begin
                    dec_stat_d = s_axis_dec_status_tdata;
                    dec_done_d = 1'b1;
                end
                // The edge carrying the last status handshake is still counted.
                if (!(enc_done_q && dec_done_q)) begin
                    elapsed_d = sat_inc(elapsed_q);
                end

                if (state_q == ST_ISSUE) begin
                    if (enc_vld_q && m_axis_enc_ctrl_tready) begin
                        enc_vld_d = 1'b0;
                    end
                    if (dec_vld_q && m_axis_dec_ctrl_tready) begin
                        dec_vld_d = 1'b0;
                    end
                    if (!enc_vld_d && !dec_vld_d) begin
                        if (enc_done_d && dec_done_d) begin
                            report_go = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end else begin
                    // A status completing on the timeout edge takes priority.
                    if (enc_done_d && dec_done_d) begin
                        report_go = 1'b1;
                    end else if (elapsed_d >= TIMEOUT_LIM) begin
                        report_go = 1'b1;
                        report_to = 1'b1;
                    end
                end
            end

            ST_REPORT: begin
                if (res_vld_q && m_axis_result_tready) begin
                    res_vld_d   = 1'b0;
                    state_d     = ST_IDLE;
                    job_count_d = sat_inc(job_count_q);
                    if (res_data_q[DATA_WIDTH-1] || res_data_q[DATA_WIDTH-2]) begin
                        error_count_d = sat_inc(error_count_q);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (report_go) begin
            state_d    = ST_REPORT;
            res_vld_d  = 1'b1;
            res_data_d = make_result(report_to,
                                     !report_to && (enc_stat_d != dec_stat_d),
                                     elapsed_d);
        end
    end

    // State and output registers; reset aborts any job in flight.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            rdy_en_q      <= 1'b0;
            job_q         <= '0;
            enc_vld_q     <= 1'b0;
            dec_vld_q     <= 1'b0;
            enc_done_q    <= 1'b0;
            dec_done_q    <= 1'b0;
            enc_stat_q    <= '0;
            dec_stat_q    <= '0;
            elapsed_q     <= '0;
            res_vld_q     <= 1'b0;
            res_data_q    <= '0;
            job_count_q   <= '0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rdy_en_q      <= 1'b1;
            job_q         <= job_d;
            enc_vld_q     <= enc_vld_d;
            dec_vld_q     <= dec_vld_d;
            enc_done_q    <= enc_done_d;
            dec_done_q    <= dec_done_d;
            enc_stat_q    <= enc_stat_d;
            dec_stat_q    <= dec_stat_d;
            elapsed_q     <= elapsed_d;
            res_vld_q     <= res_vld_d;
            res_data_q    <= res_data_d;
            job_count_q   <= job_count_d;
            error_count_q <= error_count_d;
        end
    end

endmodule
